// File: rtl/disp_scan_if.sv
// Bundle of the button, data and display-pin signals around the scan controller.
// The master side drives the button and data words; the slave side (the controller) drives the pins.
interface disp_scan_if;
  logic        btnu;
  logic [31:0] bcd;
  logic [31:0] bin;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        mode;

  modport master (
    output btnu, bcd, bin,
    input  an, seg, dp, mode
  );

  modport slave (
    input  btnu, bcd, bin,
    output an, seg, dp, mode
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Round-robin 8-digit 7-segment scanner with a per-scan frame latch, a hex/decimal
// mode toggle on a debounced button, and leading-zero blanking for decimal frames.
module disp_scan_ctrl #(
  parameter int unsigned COUNT_MAX       = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic        clk,
  input logic        reset,
  disp_scan_if.slave bus_io
);

  localparam int unsigned PW = $clog2(COUNT_MAX);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] PrescLast = PW'(COUNT_MAX - 1);
  localparam logic [DW-1:0] DbLast    = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   frame_q, frame_d;
  logic          frame_mode_q, frame_mode_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          btn_s;
  logic          db_last;
  logic          db_accept;
  logic          tc;
  logic          latch;
  logic [3:0]    nibble;
  logic [31:0]   upper;
  logic          blank;
  logic [6:0]    glyph;

  always_comb begin
    btn_s     = sync_q[1];
    db_last   = (db_cnt_q == DbLast);
    db_accept = (btn_s != stable_q) && db_last;
    stable_d  = db_accept ? btn_s : stable_q;
    db_cnt_d  = ((btn_s == stable_q) || db_last) ? '0 : db_cnt_q + 1'b1;
    // Only a rising change of the debounced level flips the mode.
    mode_d    = mode_q ^ (db_accept & btn_s);
  end

  always_comb begin
    tc           = (presc_q == PrescLast);
    presc_d      = tc ? '0 : presc_q + 1'b1;
    idx_d        = tc ? idx_q + 3'd1 : idx_q;
    latch        = tc && (idx_q == 3'd7);
    frame_d      = latch ? (mode_q ? bus_io.bcd : bus_io.bin) : frame_q;
    frame_mode_d = latch ? mode_q : frame_mode_q;
  end

  always_comb begin
    nibble = frame_q[{idx_q, 2'b00} +: 4];
    upper  = frame_q >> {idx_q, 2'b00};
    // Leading zeros are judged on this digit and every digit to its left.
    blank  = frame_mode_q && (idx_q != 3'd0) && (upper == '0);
    unique case (nibble)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    if (frame_mode_q && (nibble > 4'd9)) begin
      glyph = 7'h3F;
    end
    an_d  = blank ? 8'hFF : ~(8'd1 << idx_q);
    seg_d = blank ? 7'h7F : glyph;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      stable_q     <= 1'b0;
      db_cnt_q     <= '0;
      mode_q       <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      frame_mode_q <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
    end else begin
      sync_q       <= {sync_q[0], bus_io.btnu};
      stable_q     <= stable_d;
      db_cnt_q     <= db_cnt_d;
      mode_q       <= mode_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      frame_mode_q <= frame_mode_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign bus_io.an   = an_q;
  assign bus_io.seg  = seg_q;
  assign bus_io.dp   = 1'b1;
  assign bus_io.mode = mode_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: expected digit slots are queued when a frame's
// data is driven and popped as the scanner walks through that frame.
module tb_disp_scan_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  logic [14:0] sb_q[$];

  disp_scan_if bus ();

  disp_scan_ctrl #(
    .COUNT_MAX      (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  task automatic push_frame(input logic [31:0] v, input logic dec);
    logic [3:0]  nib;
    logic [31:0] above;
    logic [7:0]  an;
    logic [6:0]  seg;
    for (int k = 0; k < 8; k++) begin
      nib   = v[4*k +: 4];
      above = v >> (4 * k);
      if (dec && k >= 1 && above == 32'h0) begin
        an  = 8'hFF;
        seg = 7'h7F;
      end else begin
        an  = ~(8'd1 << k);
        seg = (dec && nib > 4'd9) ? 7'h3F : glyph_of(nib);
      end
      sb_q.push_back({an, seg});
    end
  endtask

  task automatic wait_latch(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (cyc % 32 == 0 && cyc != 0) found = 1'b1;
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: frame boundary not reached, cyc=%0d", name, cyc);
    end
  endtask

  // Called just after a latch edge; samples each slot mid-way and ends just after the next latch.
  task automatic check_cur_frame(input string name);
    logic [14:0] exp;
    for (int k = 0; k < 8; k++) begin
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s slot %0d: no expected entry queued", name, k);
      end else begin
        exp = sb_q.pop_front();
        if ({bus.an, bus.seg} !== exp) begin
          n_fail++;
          $display("FAIL %s slot %0d: got AN=%h SEG=%h, want AN=%h SEG=%h",
                   name, k, bus.an, bus.seg, exp[14:7], exp[6:0]);
        end
      end
      repeat (2) @(posedge clk);
    end
    #1;
  endtask

  task automatic check_frame(input string name);
    wait_latch(name);
    check_cur_frame(name);
  endtask

  task automatic check_rst_outputs(input string name);
    n_tests++;
    if (bus.an !== 8'hFF || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.mode !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got AN=%h SEG=%h DP=%b mode=%b, want AN=ff SEG=7f DP=1 mode=0",
               name, bus.an, bus.seg, bus.dp, bus.mode);
    end
  endtask

  task automatic check_first_edge(input string name);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.an !== 8'hFE || bus.seg !== 7'h40) begin
      n_fail++;
      $display("FAIL %s: got AN=%h SEG=%h, want AN=fe SEG=40", name, bus.an, bus.seg);
    end
  endtask

  task automatic check_mode(input string name, input logic want);
    n_tests++;
    if (bus.mode !== want) begin
      n_fail++;
      $display("FAIL %s: got mode=%b, want %b", name, bus.mode, want);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.btnu = 1'b0;
    bus.bcd  = 32'h0;
    bus.bin  = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    check_rst_outputs("reset_hold");
    check_first_edge("reset_release");
    n_tests++;
    if (bus.dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dp: got DP=%b, want 1", bus.dp);
    end
  endtask

  task automatic test_idle_hex();
    push_frame(32'h12345678, 1'b0);
    check_frame("idle_hex");
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 34; i++) begin
      bus.btnu = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.btnu = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    repeat (12) @(posedge clk);
    #1;
    check_mode("glitch_mode", 1'b0);
  endtask

  task automatic test_mode_toggle();
    wait_latch("toggle_align");
    bus.bcd  = 32'h00000042;
    bus.btnu = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check_mode("toggle_early", 1'b0);
    @(posedge clk);
    #1;
    check_mode("toggle_latency", 1'b1);
    repeat (2) @(posedge clk);
    #1;
    bus.btnu = 1'b0;
    push_frame(32'h00000042, 1'b1);
    check_frame("toggle_dec");
    check_mode("toggle_release", 1'b1);
  endtask

  task automatic test_decimal_dash();
    bus.bcd = 32'h0000000A;
    push_frame(32'h0000000A, 1'b1);
    check_frame("dec_dash");
  endtask

  task automatic test_midscan();
    reset   = 1'b1;
    bus.bin = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_latch("midscan_align");
    push_frame(32'h1, 1'b0);
    fork
      check_cur_frame("midscan_old");
      begin
        repeat (13) @(posedge clk);
        #1;
        bus.bin = 32'h2;
      end
    join
    push_frame(32'h2, 1'b0);
    check_cur_frame("midscan_new");
    repeat (21) @(posedge clk);
    #1;
    n_tests++;
    if (bus.an !== 8'hDF || bus.seg !== 7'h40) begin
      n_fail++;
      $display("FAIL midscan_idx5: got AN=%h SEG=%h, want AN=df SEG=40", bus.an, bus.seg);
    end
    reset = 1'b1;
    #1;
    check_rst_outputs("midscan_reset");
    check_first_edge("midscan_release");
  endtask

  initial begin
    test_reset();
    test_idle_hex();
    test_glitch();
    test_mode_toggle();
    test_decimal_dash();
    test_midscan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexing scheduler for the 8-digit, 7-segment display. Shares the common segment bus between the eight digit anodes in a round-robin scan and debounces BTNU into a hex/decimal mode toggle. Once per full scan it latches either the BCD or the binary 32-bit word as the displayed frame. It sits between the arithmetic/BCD conversion logic and the board's AN/SEG/DP pins.

## Interface
- COUNT_MAX, 100000: clock cycles each digit stays lit (1 kHz digit rate at 100 MHz); must be ≥2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a BTNU level change is accepted; must be ≥2.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- BTNU  in  1  raw push-button, asynchronous to clk.
- bcd  in  32  eight BCD nibbles; nibble k = bcd[4k+3:4k] drives digit k (digit 0 is rightmost).
- bin  in  32  eight hex nibbles, same digit mapping.
- AN  out  8  digit anodes, active low; AN[k] enables digit k.
- SEG  out  7  {CG,CF,CE,CD,CC,CB,CA}, active low.
- DP  out  1  decimal point, active low; held 1 (off).
- mode  out  1  1 = decimal (bcd) selected, 0 = hex (bin) selected.

## Operation
- Button path: 2-FF synchronizer, then debouncer.
  - The debouncer keeps a stable level and a counter. The counter clears whenever the synchronized input equals the stable level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the input still differs, the stable level takes the input value and the counter clears.
  - A 0→1 change of the stable level toggles mode. A 1→0 change has no effect.
- Scan scheduler: prescaler counts 0..COUNT_MAX-1 and wraps. Each wrap (terminal count) advances digit index idx 0→1→…→7→0.
- Frame latch: on the terminal count with idx==7 (the wrap to idx 0), frame ← (mode ? bcd : bin), using mode as registered in that cycle.
  - frame changes only here, so no tearing occurs mid-scan. A mode toggle becomes visible at the next frame boundary.
- Digit decode, nibble n = frame[4·idx+3:4·idx]:
  - hex mode: 0–F → standard glyphs (0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E).
  - decimal mode: 0–9 as above; 10–15 → '-' (0x3F).
  - The decode mode is the mode captured with the frame (frame_mode), not the live mode.
- Leading-zero blanking, decimal frames only: digit k≥1 is blanked when nibbles k..7 of frame are all zero. Digit 0 is never blanked. A blanked slot drives AN=0xFF, SEG=0x7F.
- Non-blanked slot: AN = ~(1<<idx), SEG = decoded glyph. Exactly one AN bit is low at a time.

## Timing
- Reset values:
  - Outputs: AN=0xFF, SEG=0x7F, DP=1, mode=0.
  - Internal: prescaler=0, idx=0, frame=0, frame_mode=0, debouncer stable=0 and counter=0, synchronizer=0.
- AN, SEG and DP are registered and reflect idx/frame one cycle late. The first clock edge after reset deasserts gives AN=0xFE, SEG=0x40.
- Digit slot length is COUNT_MAX cycles. The full scan period is 8·COUNT_MAX cycles.
- Button latency: a clean 0→1 press changes mode 2 (sync) + DEBOUNCE_CYCLES cycles after the raw edge. The display follows at the next frame boundary, at most 8·COUNT_MAX cycles later.
- Glitches shorter than DEBOUNCE_CYCLES clear the counter and never change the stable level or mode.
- A toggle that coincides with the frame-latch cycle is not included in that latch; it takes effect at the following frame.
- Reset asserted mid-scan or mid-debounce immediately forces all reset values. No partial frame is kept.
- bcd and bin are sampled only at the latch cycle. Changes at any other time are ignored until the next frame.

## Test plan
Parameters for all scenarios: COUNT_MAX=4, DEBOUNCE_CYCLES=8.
- Reset, then idle with bin=0x12345678, BTNU=0.
  - AN=0xFF during reset, AN=0xFE on the first edge after release.
  - After the first frame latch (cycle 32), AN steps FE,FD,…,7F every 4 cycles.
  - SEG shows 8,7,6,5,4,3,2,1 on digits 0..7.
- BTNU high for 12 cycles with bcd=0x00000042.
  - mode=1 exactly 10 cycles after the raw edge.
  - Next frame shows digit 0 '2' (0x24) and digit 1 '4' (0x19); digits 2..7 slots give AN=0xFF.
- BTNU pulses of 3 cycles high and 3 low, repeated for 200 cycles: mode stays 0.
- Decimal mode with bcd=0x0000000A: digit 0 shows '-' (0x3F); all other slots are blanked.
- bin changes from 0x1 to 0x2 at mid-scan (idx=3): displayed value stays 1 until the next latch, then becomes 2. Also assert reset at idx=5: AN=0xFF and mode=0 immediately.
